// File: rtl/keccak_squeeze_unpacker.sv
// Streams the rate part of a Keccak-f state as 64-bit words and requests more blocks for XOFs.
// Optional `SQZ_LAST_FLAG_EN adds word_last_o, flagging the final word of a request.
module keccak_squeeze_unpacker #(
   parameter int unsigned WORD_W = 64,
   parameter int unsigned LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic [LEN_W-1:0]  req_words_i,
   input  logic [1599:0]     state_in_i,
   input  logic              state_ready_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o,
   input  logic              word_ready_i,
   output logic              squeeze_o,
   output logic              busy_o,
`ifdef SQZ_LAST_FLAG_EN
   output logic              word_last_o,
`endif
   output logic              done_o
);

   localparam int unsigned NumWords = 21;
   localparam int unsigned RateW    = NumWords * WORD_W;
   localparam logic [4:0]  NumWordsK = 5'd21;

   typedef enum logic [2:0] {StIdle, StWait, StStream, StReq, StDrain, StFin} state_e;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic [4:0]         k_q, k_d;
   logic [4:0]         blk_q, blk_d;
   logic               cap;
   logic [WORD_W-1:0]  buf_q [NumWords];

   // Capacity bits beyond the rate are never emitted.
   logic unused_capacity;
   assign unused_capacity = ^state_in_i[1599:RateW];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         rem_q   <= '0;
         k_q     <= '0;
         blk_q   <= '0;
         for (int i = 0; i < NumWords; i++) buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         k_q     <= k_d;
         blk_q   <= blk_d;
         if (cap) begin
            for (int i = 0; i < NumWords; i++) buf_q[i] <= state_in_i[i*WORD_W +: WORD_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      k_d     = k_q;
      blk_d   = blk_q;
      cap     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               unique case (mode_i)
                  2'b00: begin rem_d = req_words_i;   blk_d = 5'd21; end
                  2'b10: begin rem_d = req_words_i;   blk_d = 5'd17; end
                  2'b01: begin rem_d = LEN_W'(4);     blk_d = 5'd17; end
                  2'b11: begin rem_d = LEN_W'(8);     blk_d = 5'd9;  end
               endcase
               state_d = (rem_d == '0) ? StFin : StWait;
            end
         end
         StWait: begin
            if (state_ready_i) begin
               cap     = 1'b1;
               k_d     = '0;
               state_d = StStream;
            end
         end
         StStream: begin
            if (word_ready_i) begin
               k_d   = k_q + 5'd1;
               rem_d = (rem_q != '0) ? rem_q - LEN_W'(1) : '0;
               if (rem_q <= LEN_W'(1)) begin
                  state_d = StFin;
               end else if (k_d == blk_q) begin
                  state_d = StReq;
               end
            end
         end
         StReq:   state_d = StDrain;
         // The core keeps out_ready high briefly after squeeze; only a low phase marks a new block.
         StDrain: if (!state_ready_i) state_d = StWait;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o       = (state_q != StIdle);
      word_valid_o = (state_q == StStream);
      squeeze_o    = (state_q == StReq);
      done_o       = (state_q == StFin);
      word_o       = '0;
      if (word_valid_o && (k_q < NumWordsK)) word_o = buf_q[k_q];
`ifdef SQZ_LAST_FLAG_EN
      word_last_o  = word_valid_o && (rem_q == LEN_W'(1));
`endif
   end

endmodule

// File: tb/tb_keccak_squeeze_unpacker.sv
// Directed bench for keccak_squeeze_unpacker with a queue scoreboard and a simple core model.
module tb_keccak_squeeze_unpacker;

   logic          clk = 1'b0;
   logic          reset, start, state_ready, word_ready;
   logic [1:0]    mode;
   logic [15:0]   req_words;
   logic [1599:0] state_in;
   logic [63:0]   word;
   logic          word_valid, squeeze, busy, done;
`ifdef SQZ_LAST_FLAG_EN
   logic          word_last;
`endif

   always #5 clk = ~clk;

   keccak_squeeze_unpacker #(.WORD_W(64), .LEN_W(16)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .mode_i        (mode),
      .req_words_i   (req_words),
      .state_in_i    (state_in),
      .state_ready_i (state_ready),
      .word_o        (word),
      .word_valid_o  (word_valid),
      .word_ready_i  (word_ready),
      .squeeze_o     (squeeze),
      .busy_o        (busy),
`ifdef SQZ_LAST_FLAG_EN
      .word_last_o   (word_last),
`endif
      .done_o        (done)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int beat_cnt = 0, sqz_cnt = 0, done_cnt = 0, valid_cnt = 0;
   int req_total = 0, req_beat = 0;
   int b0, s0, d0, v0;
   bit prev_stall = 1'b0;
   logic [63:0] prev_word;
   logic [63:0] exp_q [$];

   function automatic logic [63:0] wgen(input int unsigned seed, input int unsigned i);
      return {16'(seed), 16'h0123, 16'h89ab, 16'(i)};
   endfunction

   function automatic logic [1599:0] mk_state(input int unsigned seed);
      logic [1599:0] s;
      for (int i = 0; i < 25; i++) s[i*64 +: 64] = wgen(seed, i);
      return s;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic push_words(input int unsigned seed, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(wgen(seed, i));
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (squeeze) sqz_cnt++;
            if (done) done_cnt++;
            if (word_valid) begin
               valid_cnt++;
               if (prev_stall) check("stall_hold", word, prev_word);
               if (word_ready) begin
                  beat_cnt++;
                  req_beat++;
                  if (exp_q.size() == 0) check("extra_word", word, 64'hx);
                  else check("word", word, exp_q.pop_front());
`ifdef SQZ_LAST_FLAG_EN
                  check("word_last", 64'(word_last), 64'(req_beat == req_total));
`endif
               end
               prev_stall = !word_ready;
               prev_word  = word;
            end else begin
               prev_stall = 1'b0;
            end
         end
      end
   endtask

   task automatic snap();
      b0 = beat_cnt; s0 = sqz_cnt; d0 = done_cnt; v0 = valid_cnt;
   endtask

   task automatic do_start(input logic [1:0] m, input logic [15:0] n);
      @(posedge clk); #1;
      mode = m; req_words = n; start = 1'b1;
      req_beat = 0;
      req_total = (m == 2'b01) ? 4 : (m == 2'b11) ? 8 : int'(n);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Runs until done, modelling the core: out_ready stays high for two cycles after squeeze,
   // drops, then rises again with the next block.
   task automatic run_to_done(input string tag, input int budget, input bit toggle,
                              input logic [1599:0] nxt);
      int cnt = 0;
      int ph = 0;
      while (done_cnt == d0 && cnt < budget) begin
         @(posedge clk); #1;
         cnt++;
         if (toggle) word_ready = ~word_ready;
         if (squeeze) ph = 1;
         else if (ph > 0) begin
            ph++;
            if (ph == 4) state_ready = 1'b0;
            if (ph == 6) begin state_in = nxt; state_ready = 1'b1; ph = 0; end
         end
      end
      word_ready = 1'b1;
      check({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
      check({tag, "_sbempty"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 2'b00; req_words = '0;
      state_in = '0; state_ready = 1'b0; word_ready = 1'b1;
      fork monitor(); join_none
      repeat (2) @(posedge clk);
      #1;
      check("rst_word", word, 64'd0);
      check("rst_valid", 64'(word_valid), 64'd0);
      check("rst_squeeze", 64'(squeeze), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      reset = 1'b0;

      // SHA3-256: four consecutive words, no squeeze.
      state_in = mk_state(1); state_ready = 1'b1;
      push_words(1, 4); snap();
      do_start(2'b01, 16'd99);
      run_to_done("m01", 100, 1'b0, mk_state(1));
      check("m01_beats", 64'(beat_cnt - b0), 64'd4);
      check("m01_consec", 64'(valid_cnt - v0), 64'd4);
      check("m01_sqz", 64'(sqz_cnt - s0), 64'd0);

      // SHAKE128 spanning two blocks.
      state_in = mk_state(2); state_ready = 1'b1;
      push_words(2, 21); push_words(3, 9); snap();
      do_start(2'b00, 16'd30);
      run_to_done("m00", 300, 1'b0, mk_state(3));
      check("m00_beats", 64'(beat_cnt - b0), 64'd30);
      check("m00_sqz", 64'(sqz_cnt - s0), 64'd1);

      // SHAKE256 exactly one block with a stalling consumer.
      state_in = mk_state(4); state_ready = 1'b1;
      push_words(4, 17); snap();
      do_start(2'b10, 16'd17);
      run_to_done("m10", 300, 1'b1, mk_state(5));
      check("m10_beats", 64'(beat_cnt - b0), 64'd17);
      check("m10_sqz", 64'(sqz_cnt - s0), 64'd0);

      // Zero-length request.
      snap();
      do_start(2'b00, 16'd0);
      check("zero_done", 64'(done), 64'd1);
      check("zero_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      check("zero_done_end", 64'(done), 64'd0);
      check("zero_busy_end", 64'(busy), 64'd0);
      check("zero_valid", 64'(valid_cnt - v0), 64'd0);
      check("zero_sqz", 64'(sqz_cnt - s0), 64'd0);

      // Abort by reset after five beats.
      state_in = mk_state(6); state_ready = 1'b1;
      push_words(6, 5); snap();
      do_start(2'b10, 16'd40);
      for (int i = 0; i < 100 && (beat_cnt - b0) < 5; i++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1; word_ready = 1'b0;
      @(posedge clk); #1;
      check("abort_beats", 64'(beat_cnt - b0), 64'd5);
      check("abort_word", word, 64'd0);
      check("abort_valid", 64'(word_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_squeeze", 64'(squeeze), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      reset = 1'b0; word_ready = 1'b1;
      check("abort_nodone", 64'(done_cnt - d0), 64'd0);
      check("abort_sbempty", 64'(exp_q.size()), 64'd0);

      // Fresh 3-word request with a stray start while streaming.
      state_in = mk_state(7);
      push_words(7, 3); snap();
      req_beat = 0; req_total = 3;
      mode = 2'b10; req_words = 16'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      mode = 2'b00; req_words = 16'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mode = 2'b10;
      run_to_done("restart", 100, 1'b0, mk_state(8));
      check("restart_beats", 64'(beat_cnt - b0), 64'd3);
      check("restart_sqz", 64'(sqz_cnt - s0), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/keccak_squeeze_unpacker.md
Name: keccak_squeeze_unpacker

Overview:
- Sits directly downstream of the pipelined Keccak-f permutation core. It takes the 1600-bit state when the core raises `out_ready`.
- Captures the rate portion of that state and streams it as 64-bit little-endian words to Dilithium consumers (rejection samplers, hash outputs).
- When an XOF request needs more words than one block holds, it drives the core's `squeeze` input to get further permutations, until the requested word count is delivered.

Parameters:
- WORD_W, 64, output word width in bits (only 64 is supported).
- LEN_W, 16, width of the requested-word-count field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- mode  input  2  00 SHAKE128 (21 words/block), 10 SHAKE256 (17 words/block), 01 SHA3-256 (4 words, single block), 11 SHA3-512 (8 words, single block).
- req_words  input  LEN_W  XOF word count; ignored for modes 01 and 11.
- state_in  input  1600  permutation state (core `out`).
- state_ready  input  1  core `out_ready`.
- word  output  64  current output word.
- word_valid  output  1  `word` is valid.
- word_ready  input  1  consumer accepts `word`.
- squeeze  output  1  one-cycle pulse to the core's `squeeze` input.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the final word is accepted.

Behaviour:
- Reset:
  - State goes to IDLE.
  - `word`=0, `word_valid`=0, `squeeze`=0, `busy`=0, `done`=0.
  - Internal counters and the 1344-bit capture buffer are cleared.
  - A reset in any state aborts the transfer; no `done` is issued.
- Latching at start: `start` in IDLE latches `mode` and the remaining count `rem`.
  - Modes 00/10: `rem` = `req_words`.
  - Mode 01: `rem` = 4.
  - Mode 11: `rem` = 8.
  - Block size `blk`: 21 for mode 00, 17 for modes 10 and 01, 9 for mode 11.
- Zero-length request: if `rem`==0 at start, go to FIN. `done` pulses the next cycle and no words or `squeeze` are issued.
- IDLE:
  - `start` goes to WAIT.
  - `start` in any other state is ignored.
- WAIT:
  - Stays until `state_ready`==1.
  - On that cycle, capture `state_in[1343:0]` into the buffer, set word index `k`=0, go to STREAM.
- STREAM:
  - `word` = `buf[64k+63:64k]`, `word_valid`=1. `word` stays stable while `word_valid` && !`word_ready`.
  - A beat completes on `word_valid` && `word_ready`: `k` increments and `rem` decrements.
  - The next word is presented the following cycle, giving a maximum of one word per cycle.
  - After the beat on which `rem` becomes 0: `word_valid`=0, go to FIN.
  - After the beat on which `k` reaches `blk` with `rem`>0: `word_valid`=0, go to REQ. In modes 01/11 this cannot occur.
- REQ:
  - Pulse `squeeze`=1 for exactly one cycle, then go to DRAIN.
- DRAIN:
  - Wait for `state_ready`==0, which means the core has begun the next permutation, then go to WAIT.
  - `state_ready` still high in the same cycle is not treated as a new block.
- FIN:
  - `done`=1 for one cycle, then IDLE.
  - `busy` falls in the same cycle IDLE is entered.
- Latency:
  - First word is valid 1 cycle after capture: `state_ready` seen in WAIT at cycle n gives `word_valid` at n+1.
  - From the last beat of a block to the `squeeze` pulse: 1 cycle.
- Counters:
  - `rem` is LEN_W bits and never wraps; it saturates at 0.
  - `k` is 5 bits and is reset to 0 on each capture.

Optional Feature:
- Macro `SQZ_LAST_FLAG_EN`.
- When defined: adds output port `word_last` (1 bit). It is high with `word_valid` on the final word of the request (`rem`==1), 0 otherwise, and resets to 0.
- When undefined: the port does not exist and behaviour is otherwise identical.

Test Plan:
- Mode 01, start, `state_ready` rising with `state_in[255:0]`=0x…0123 pattern, `word_ready`=1 → exactly 4 words equal to bits [63:0]..[255:192] on consecutive cycles, then a `done` pulse, `squeeze` never asserted.
- Mode 00, `req_words`=30, `word_ready`=1 → 21 words from block 1, one `squeeze` pulse, DRAIN waits for `state_ready` low then high, 9 words from block 2, then `done`; total 30 beats.
- Mode 10, `req_words`=17, `word_ready` toggling 1-0-1-0 → 17 beats; `word` stable during stalls; `done` with no `squeeze` (the count exactly fills the block).
- Mode 00, `req_words`=0 → `done` one cycle after `start`, `word_valid` never high, `busy` high for 1 cycle.
- Reset asserted in STREAM after 5 beats (mode 10, `req_words`=40) → the next cycle shows all outputs at 0 and IDLE; a new start with `req_words`=3 delivers 3 fresh words.
- `start` pulsed again during STREAM → ignored; the count and the word sequence are unchanged. With `SQZ_LAST_FLAG_EN` set, `word_last` is high only on beat 3 of a 3-word request.
